// File: rtl/signed_negate_pipe.sv
// rtl/signed_negate_pipe.sv - two-stage signed pass/negate/abs/abs-diff pipeline with overflow counter
// Build macro SIGNED_NEGATE_SAT_EN: overflowed results saturate to max positive instead of wrapping.
module signed_negate_pipe #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             ovf,
  output logic [CNT_W-1:0] ovf_cnt,
  input  logic             cnt_clr
);

  typedef enum logic [1:0] {
    MODE_PASS     = 2'd0,
    MODE_NEG      = 2'd1,
    MODE_ABS      = 2'd2,
    MODE_ABS_DIFF = 2'd3
  } mode_e;

  localparam logic [WIDTH-1:0] MIN_NEG     = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_POS     = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] ONE_W       = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   ONE_X       = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   MAX_POS_X   = {2'b00, {(WIDTH-1){1'b1}}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  mode_e            s1_mode;
  logic [WIDTH:0]   s1_diff;
  logic             s2_valid;

  logic             s2_load;
  logic             out_fire;
  logic [WIDTH:0]   a_ext;
  logic [WIDTH:0]   b_ext;

  logic [WIDTH-1:0] neg_a;
  logic             a_is_min;
  logic [WIDTH:0]   abs_d;
  logic [WIDTH-1:0] res_y;
  logic             res_ovf;

  // A stage may accept whenever it is empty or the stage after it is draining.
  assign in_ready  = !s1_valid || !s2_valid || out_ready;
  assign s2_load   = !s2_valid || out_ready;
  assign out_valid = s2_valid;
  assign out_fire  = s2_valid && out_ready;

  // Sign-extend to WIDTH+1 so a-b never overflows its own container.
  assign a_ext = {a[WIDTH-1], a};
  assign b_ext = {b[WIDTH-1], b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_mode  <= MODE_PASS;
      s1_diff  <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a    <= a;
        s1_mode <= mode_e'(mode);
        s1_diff <= a_ext - b_ext;
      end
    end
  end

  always_comb begin
    neg_a    = ~s1_a + ONE_W;
    a_is_min = (s1_a == MIN_NEG);
    abs_d    = s1_diff[WIDTH] ? (~s1_diff + ONE_X) : s1_diff;
    res_y    = s1_a;
    res_ovf  = 1'b0;
    case (s1_mode)
      MODE_PASS: begin
        res_y   = s1_a;
        res_ovf = 1'b0;
      end
      MODE_NEG: begin
        res_y   = neg_a;
        res_ovf = a_is_min;
      end
      MODE_ABS: begin
        res_y   = s1_a[WIDTH-1] ? neg_a : s1_a;
        res_ovf = a_is_min;
      end
      MODE_ABS_DIFF: begin
        res_y   = abs_d[WIDTH-1:0];
        res_ovf = (abs_d > MAX_POS_X);
      end
      default: begin
        res_y   = s1_a;
        res_ovf = 1'b0;
      end
    endcase
`ifdef SIGNED_NEGATE_SAT_EN
    if (res_ovf) begin
      res_y = MAX_POS;
    end
`else
    // Overflowed results keep the wrapped low WIDTH bits.
    res_y = res_y;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      y        <= '0;
      ovf      <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        y   <= res_y;
        ovf <= res_ovf;
      end
    end
  end

  // Clear takes priority over a same-cycle counting handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
    end else if (cnt_clr) begin
      ovf_cnt <= '0;
    end else if (out_fire && ovf && !(&ovf_cnt)) begin
      ovf_cnt <= ovf_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_signed_negate_pipe.sv
// tb/tb_signed_negate_pipe.sv - scoreboard bench for signed_negate_pipe
module tb_signed_negate_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [1:0]  mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] y;
  logic        ovf;
  logic [7:0]  ovf_cnt;
  logic        cnt_clr = 1'b0;

  signed_negate_pipe #(.WIDTH(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .ovf(ovf), .ovf_cnt(ovf_cnt), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] y;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [1:0]  m;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] yw;
    logic [15:0] ys;
    logic        o;
  } vec_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  int          acc_cnt = 0;
  int          del_cnt = 0;
  logic [7:0]  exp_cnt = '0;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_y = '0;
  logic        prev_ovf = 1'b0;
  bit          saw_block = 1'b0;
  exp_t        e_mon;
  bit          hs_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] yw, input logic [15:0] ys, input logic o);
    exp_t e;
`ifdef SIGNED_NEGATE_SAT_EN
    e.y = ys;
`else
    e.y = yw;
`endif
    e.ovf = o;
    return e;
  endfunction

  // Monitor: samples on the falling edge, i.e. what the next rising edge will act on.
  always @(negedge clk) begin
    if (!rst_n) begin
      acc_cnt    = 0;
      del_cnt    = 0;
      exp_cnt    = '0;
      prev_stall = 1'b0;
    end else begin
      check("in_ready", {31'd0, in_ready}, {31'd0, ((acc_cnt - del_cnt) < 2) || out_ready});
      check("ovf_cnt", {24'd0, ovf_cnt}, {24'd0, exp_cnt});
      if (!in_ready) saw_block = 1'b1;
      if (prev_stall) begin
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_y", {16'd0, y}, {16'd0, prev_y});
        check("stall_ovf", {31'd0, ovf}, {31'd0, prev_ovf});
      end
      hs_ovf = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_out: got y=%h ovf=%b, expected no beat", y, ovf);
        end else begin
          e_mon = exp_q.pop_front();
          check("y", {16'd0, y}, {16'd0, e_mon.y});
          check("ovf", {31'd0, ovf}, {31'd0, e_mon.ovf});
          hs_ovf = e_mon.ovf;
        end
        del_cnt++;
      end
      if (cnt_clr) exp_cnt = '0;
      else if (hs_ovf && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      if (in_valid && in_ready) acc_cnt++;
      prev_stall = out_valid && !out_ready;
      prev_y     = y;
      prev_ovf   = ovf;
    end
  end

  task automatic send(input logic [1:0] m, input logic [15:0] va, input logic [15:0] vb, input exp_t e);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    mode = m;
    a = va;
    b = vb;
    exp_q.push_back(e);
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_bad++;
      $display("FAIL send_timeout: got in_ready=0 for 200 cycles, expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(posedge clk);
    #1;
    check("drain", exp_q.size(), 32'd0);
  endtask

  vec_t tbl[15] = '{
    '{2'd0, 16'h1234, 16'h0000, 16'h1234, 16'h1234, 1'b0},
    '{2'd0, 16'h8000, 16'h0000, 16'h8000, 16'h8000, 1'b0},
    '{2'd1, 16'h8000, 16'h0000, 16'h8000, 16'h7FFF, 1'b1},
    '{2'd1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0},
    '{2'd1, 16'h7FFF, 16'h0000, 16'h8001, 16'h8001, 1'b0},
    '{2'd2, 16'hFFFF, 16'h0000, 16'h0001, 16'h0001, 1'b0},
    '{2'd2, 16'h8000, 16'h0000, 16'h8000, 16'h7FFF, 1'b1},
    '{2'd2, 16'h8001, 16'h0000, 16'h7FFF, 16'h7FFF, 1'b0},
    '{2'd3, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h7FFF, 1'b1},
    '{2'd3, 16'h0003, 16'h000A, 16'h0007, 16'h0007, 1'b0},
    '{2'd3, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h7FFF, 1'b1},
    '{2'd3, 16'h0000, 16'h8001, 16'h7FFF, 16'h7FFF, 1'b0},
    '{2'd3, 16'h8000, 16'h0000, 16'h8000, 16'h7FFF, 1'b1},
    '{2'd3, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 1'b0},
    '{2'd3, 16'hFFFF, 16'h0001, 16'h0002, 16'h0002, 1'b0}
  };

  vec_t strm[10] = '{
    '{2'd2, 16'h0001, 16'h0000, 16'h0001, 16'h0001, 1'b0},
    '{2'd2, 16'hFFFF, 16'h0000, 16'h0001, 16'h0001, 1'b0},
    '{2'd2, 16'h8000, 16'h0000, 16'h8000, 16'h7FFF, 1'b1},
    '{2'd2, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h7FFF, 1'b0},
    '{2'd2, 16'hFFF6, 16'h0000, 16'h000A, 16'h000A, 1'b0},
    '{2'd2, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0},
    '{2'd2, 16'h8001, 16'h0000, 16'h7FFF, 16'h7FFF, 1'b0},
    '{2'd2, 16'h1234, 16'h0000, 16'h1234, 16'h1234, 1'b0},
    '{2'd2, 16'hEDCC, 16'h0000, 16'h1234, 16'h1234, 1'b0},
    '{2'd2, 16'hC000, 16'h0000, 16'h4000, 16'h4000, 1'b0}
  };

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_y", {16'd0, y}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    check("rst_ovf_cnt", {24'd0, ovf_cnt}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    #3 rst_n = 1'b1;

    // Latency: first beat after release, on an empty pipe.
    send(2'd1, 16'h0005, 16'h0000, mk(16'hFFFB, 16'hFFFB, 1'b0));
    check("lat_after_accept", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("lat_second_edge", {31'd0, out_valid}, 32'd1);
    check("lat_y", {16'd0, y}, 32'h0000FFFB);
    drain();

    foreach (tbl[i]) send(tbl[i].m, tbl[i].a, tbl[i].b, mk(tbl[i].yw, tbl[i].ys, tbl[i].o));
    drain();

    saw_block = 1'b0;
    fork
      begin
        foreach (strm[i]) send(strm[i].m, strm[i].a, strm[i].b, mk(strm[i].yw, strm[i].ys, strm[i].o));
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("stall_blocked_input", {31'd0, saw_block}, 32'd1);

    repeat (300) send(2'd1, 16'h8000, 16'h0000, mk(16'h8000, 16'h7FFF, 1'b1));
    check("cnt_saturated", {24'd0, ovf_cnt}, 32'h000000FF);
    check("clr_coincident_hs", {31'd0, out_valid && out_ready && ovf}, 32'd1);
    cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    check("cnt_clr_wins", {24'd0, ovf_cnt}, 32'd0);
    drain();

    // Asynchronous reset with two beats in flight.
    send(2'd0, 16'hAAAA, 16'h0000, mk(16'hAAAA, 16'hAAAA, 1'b0));
    send(2'd0, 16'h5555, 16'h0000, mk(16'h5555, 16'h5555, 1'b0));
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_y", {16'd0, y}, 32'd0);
    check("arst_ovf_cnt", {24'd0, ovf_cnt}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_stale_beat", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    send(2'd3, 16'h0003, 16'h000A, mk(16'h0007, 16'h0007, 1'b0));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected completion");
    $fatal(1);
  end

endmodule
